dram_lsu: RTL
=============

// Module: dram_lsu
// PURPOSE
//  Load/store sequencer between the CPU MEM stage and dram_driver. Accepts one
//  load/store per valid/ready handshake and checks alignment, funct3 and the
//  DRAM address window. Drives dram_driver's addr/wdata/mask/wen for a fixed
//  access window, applies load sign-extension and returns a held response.
// PARAMETERS
//  DRAM_BASE   32'h8010_0000  byte base of DRAM window
//  DRAM_AW     18             DRAM byte-address width (window = 2**DRAM_AW bytes)
//  ACC_CYC     1              access-window length in cycles, legal 1..4
// PORTS
//  clk          in   1   system clock, all state on posedge
//  rst          in   1   asynchronous, active-high reset
//  req_valid    in   1   MEM-stage request valid
//  req_ready    out  1   request accepted when req_valid&&req_ready at posedge
//  req_we       in   1   1=store, 0=load
//  req_funct3   in   3   RV32I funct3 of the load/store
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data, right-aligned (byte/half in low bits)
//  rsp_valid    out  1   response valid, held until rsp_ready
//  rsp_ready    in   1   consumer accepts response
//  rsp_rdata    out  32  load result, sign/zero-extended; 0 for stores/errors
//  rsp_err      out  1   misaligned, illegal funct3 or address outside window
//  perip_addr   out  18  to dram_driver: req_addr - DRAM_BASE, low DRAM_AW bits
//  perip_wdata  out  32  to dram_driver: req_wdata
//  perip_mask   out  2   to dram_driver: 00 byte, 01 half, 10 word
//  dram_wen     out  1   to dram_driver write enable
//  perip_rdata  in   32  from dram_driver, zero-extended, combinational read
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, dram_wen=0,
//   perip_addr=0, perip_wdata=0, perip_mask=0. The reset clears dram_wen
//   asynchronously. A reset during ACCESS/RESP aborts the request without a write.
//  req_ready = (state==IDLE). All dram_driver outputs are registered at accept.
//  Decode at accept: load f3 000 lb, 100 lbu, 001 lh, 101 lhu, 010 lw.
//   Store f3 000 sb, 001 sh, 010 sw. Any other code is illegal.
//   mask = f3[1:0]. half needs addr[0]=0; word needs addr[1:0]=0.
//   In window: DRAM_BASE <= addr < DRAM_BASE + 2**DRAM_AW (32-bit unsigned compare).
//  FSM:
//   IDLE -> ACCESS when accepted and no error; cnt=ACC_CYC-1.
//   IDLE -> RESP when accepted with an error. rsp_err=1, rsp_rdata=0, dram_wen never rises.
//   ACCESS: perip_* held stable; cnt decrements each cycle.
//    Store: dram_wen=1 only in the final ACCESS cycle (cnt==0), for exactly one
//     clock. Earlier cycles give dram_driver a stable read for byte/half RMW.
//    Load: perip_rdata is sampled at the final ACCESS posedge. Extension:
//     lb  {24{d[7]},d[7:0]}, lbu {24'b0,d[7:0]}, lh {16{d[15]},d[15:0]},
//     lhu {16'b0,d[15:0]}, lw d. Bits above the access size are ignored.
//   ACCESS -> RESP after cnt==0. dram_wen is 0 from the RESP cycle on.
//   RESP: rsp_valid=1 and rsp_* stable until rsp_valid&&rsp_ready at posedge.
//    Then -> IDLE with rsp_valid=0. No same-cycle re-accept.
//  Latency, no stall: accept at edge E. rsp_valid is high after edge E+ACC_CYC.
//   Error responses are high after E+1. Throughput: one request per ACC_CYC+2 cycles.
//  rsp_ready while not in RESP is ignored. req_* are ignored unless req_ready.
//  perip_addr keeps its last value outside ACCESS. dram_wen is 0 in IDLE/RESP.
// TESTING
//  sw 0x8010_0004 <- 0xDEADBEEF, then lw same -> one dram_wen pulse; rsp_rdata=0xDEADBEEF.
//  sb 0x8010_0005 <- 0x80, then lb 0x8010_0005 -> 0xFFFF_FF80; lbu -> 0x0000_0080;
//   lw 0x8010_0004 -> 0xDEAD80EF.
//  lh 0x8010_0003 or sw 0x8010_0002 -> rsp_err=1, rsp_rdata=0, dram_wen stays 0,
//   response after 1 cycle.
//  lw 0x8014_0000 (just past window) and funct3=011 -> rsp_err=1, no DRAM access.
//  ACC_CYC=3 store: dram_wen high only in 3rd ACCESS cycle. Hold rsp_ready=0
//   for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready=0 throughout.
//  Assert rst on the store's final ACCESS cycle -> dram_wen drops immediately;
//   memory is unchanged; req_ready=1 after release.

Source files
------------

// File: rtl/dram_lsu.sv
// Load/store sequencer between the CPU MEM stage and dram_driver.
// Checks each request, drives a fixed-length DRAM access window and returns a held response.
module dram_lsu #(
  parameter logic [31:0] DRAM_BASE = 32'h8010_0000,
  parameter int          DRAM_AW   = 18,
  parameter int          ACC_CYC   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [2:0]         req_funct3,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_rdata,
  output logic               rsp_err,
  output logic [DRAM_AW-1:0] perip_addr,
  output logic [31:0]        perip_wdata,
  output logic [1:0]         perip_mask,
  output logic               dram_wen,
  input  logic [31:0]        perip_rdata
);

  // state  | meaning
  // IDLE   | ready for a request
  // ACCESS | perip_* held, cnt counts down to the final access cycle
  // RESP   | response held until rsp_ready
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [1:0]  CNT_INIT = 2'(ACC_CYC - 1);
  localparam logic [32:0] WIN_LO   = {1'b0, DRAM_BASE};
  localparam logic [32:0] WIN_HI   = {1'b0, DRAM_BASE} + (33'd1 << DRAM_AW);

  state_t               state_q;
  logic [1:0]           cnt_q;
  logic                 we_q;
  logic [2:0]           f3_q;
  logic                 rsp_valid_q;
  logic [31:0]          rsp_rdata_q;
  logic                 rsp_err_q;
  logic [DRAM_AW-1:0]   perip_addr_q;
  logic [31:0]          perip_wdata_q;
  logic [1:0]           perip_mask_q;
  logic                 dram_wen_q;

  logic                 f3_ok_d;
  logic                 misal_d;
  logic                 in_win_d;
  logic                 req_err_d;
  logic [DRAM_AW-1:0]   offs_d;
  logic [31:0]          rdata_ext_d;

  always_comb begin
    f3_ok_d = 1'b0;
    if (req_we) f3_ok_d = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    else        f3_ok_d = (req_funct3 == 3'b000) || (req_funct3 == 3'b100) || (req_funct3 == 3'b001)
                          || (req_funct3 == 3'b101) || (req_funct3 == 3'b010);
    misal_d   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    in_win_d  = ({1'b0, req_addr} >= WIN_LO) && ({1'b0, req_addr} < WIN_HI);
    req_err_d = !f3_ok_d || misal_d || !in_win_d;
    // Only the low DRAM_AW bits of the offset survive, so the subtraction is done at that width.
    offs_d    = req_addr[DRAM_AW-1:0] - DRAM_BASE[DRAM_AW-1:0];
  end

  always_comb begin
    rdata_ext_d = perip_rdata;
    case (f3_q)
      3'b000:  rdata_ext_d = {{24{perip_rdata[7]}}, perip_rdata[7:0]};
      3'b100:  rdata_ext_d = {24'b0, perip_rdata[7:0]};
      3'b001:  rdata_ext_d = {{16{perip_rdata[15]}}, perip_rdata[15:0]};
      3'b101:  rdata_ext_d = {16'b0, perip_rdata[15:0]};
      default: rdata_ext_d = perip_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= 2'd0;
      we_q          <= 1'b0;
      f3_q          <= 3'b000;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 32'd0;
      rsp_err_q     <= 1'b0;
      perip_addr_q  <= '0;
      perip_wdata_q <= 32'd0;
      perip_mask_q  <= 2'b00;
      dram_wen_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q          <= req_we;
            f3_q          <= req_funct3;
            perip_addr_q  <= offs_d;
            perip_wdata_q <= req_wdata;
            perip_mask_q  <= req_funct3[1:0];
            if (req_err_d) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= 32'd0;
            end else begin
              state_q    <= ACCESS;
              cnt_q      <= CNT_INIT;
              dram_wen_q <= req_we && (CNT_INIT == 2'd0);
            end
          end
        end
        ACCESS: begin
          if (cnt_q == 2'd0) begin
            state_q     <= RESP;
            dram_wen_q  <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= we_q ? 32'd0 : rdata_ext_d;
          end else begin
            cnt_q      <= cnt_q - 2'd1;
            // Write strobe lands only in the last cycle of the window.
            dram_wen_q <= we_q && (cnt_q == 2'd1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign perip_addr  = perip_addr_q;
  assign perip_wdata = perip_wdata_q;
  assign perip_mask  = perip_mask_q;
  assign dram_wen    = dram_wen_q;

endmodule
